mult_rr_scheduler: RTL
======================

// Module: mult_rr_scheduler
// PURPOSE
// Shares one sequential shift-and-add multiplier datapath among NREQ requesters.
// Arbitration is round-robin and each requester uses a valid/ready handshake.
// The block grants one requester, runs the W-cycle shift-add sequence, then
// returns the 2W-bit product tagged with the requester index. It sits between
// multiple operand producers and a single result consumer.
// PARAMETERS
// W     8  operand width (unsigned); product is 2*W bits
// NREQ  4  number of requesters (>=2); IDW = $clog2(NREQ)
// PORTS
// clk        in   1         clock, all state updates on posedge
// rst        in   1         reset, synchronous, active-high
// req_valid  in   NREQ      per-requester operand valid
// req_ready  out  NREQ      per-requester accept (one-hot or zero)
// req_a      in   NREQ*W    multiplicand; requester i in bits [i*W +: W]
// req_b      in   NREQ*W    multiplier; requester i in bits [i*W +: W]
// rsp_valid  out  1         product available
// rsp_ready  in   1         consumer accepts product
// rsp_id     out  IDW       index of the requester that owns rsp_prod
// rsp_prod   out  2*W       unsigned product a*b
// busy       out  1         high in any state other than IDLE
// BEHAVIOUR
// Reset:
// - state=IDLE, rr pointer=0, rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0,
//   internal count/acc/regs=0.
// - Reset mid-operation abandons the job; no response is produced.
// FSM IDLE -> RUN -> DONE -> IDLE.
// IDLE:
// - req_ready is combinational. It is one-hot on the first valid requester
//   searching pointer, pointer+1, ... modulo NREQ, and zero if none are valid.
// - On a grant, latch m=a_i, q=b_i, id=i, acc=0, cnt=W; go to RUN.
// - Set pointer=(i+1) mod NREQ.
// RUN (exactly W cycles):
// - Each cycle: if q[0], {c,acc}=acc+m (W+1 bits, carry kept).
// - Then {c,acc,q} is shifted right by 1 and cnt decrements.
// - When cnt reaches 1, go to DONE on the next edge with rsp_prod={acc,q}.
// DONE:
// - rsp_valid=1; rsp_prod and rsp_id are held stable.
// - On rsp_ready=1: rsp_valid=0 next cycle, state goes to IDLE.
// - req_ready=0 in RUN and DONE. No overlap: a new grant is only possible
//   in IDLE, the cycle after the response handshake.
// Latency and throughput:
// - Grant at edge T gives rsp_valid=1 from cycle T+W+1.
// - Minimum issue interval is W+2 cycles.
// Other rules:
// - rsp_prod/rsp_id keep their last value after the handshake until the
//   next DONE.
// - req_valid must hold until accepted. Withdrawal before the grant is
//   allowed and simply skipped.
// - Widths: full 2W product, no truncation or overflow; a=0 or b=0 gives 0.
// - Requesters that are not valid never receive req_ready.
// TESTING
// 1. Single req1 a=255 b=255, rsp_ready=1 -> rsp_prod=65025, rsp_id=1,
//    rsp_valid exactly W+1 cycles after grant.
// 2. All 4 valid from reset with distinct operands (3*5, 7*9, 200*200,
//    0*77) -> grants in order 0,1,2,3; products 15, 63, 40000, 0.
// 3. Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid,
//    rsp_prod, rsp_id stable; req_ready=0; then one handshake.
// 4. Fairness: req0 and req2 always valid -> grants alternate 0,2,0,2;
//    req0 is never granted twice in a row.
// 5. Reset asserted at RUN cycle 3 -> next cycle state=IDLE, rsp_valid=0,
//    pointer=0, no response emitted for the aborted job.
// 6. Carry path: a=128 b=255 -> 32640; a=1 b=1 -> 1; check each
//    product over all ids.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one W-cycle shift-and-add multiplier among NREQ
// requesters; each product is returned tagged with the index of its requester.
module mult_rr_scheduler #(
    parameter  int W    = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_prod,
    output logic                busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [W-1:0]    m;
    logic [W-1:0]    q;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W:0]      sum;
    logic [W-1:0]    nxt_acc;
    logic [W-1:0]    nxt_q;

    // First valid requester at or after the round-robin pointer, wrapping modulo NREQ.
    // NOTE: every always_comb output is given a default before the loop so no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(ptr) + 32'(i)) % 32'(NREQ));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
                sel_a     = req_a[32'(cand)*W +: W];
                sel_b     = req_b[32'(cand)*W +: W];
            end
        end
    end

    assign req_ready = (state == IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
    assign busy      = (state != IDLE);

    // One shift-add step: conditional add with carry kept, then shift {c,acc,q} right.
    assign sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    assign nxt_acc = sum[W:1];
    assign nxt_q   = {sum[0], q[W-1:1]};

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            m         <= '0;
            q         <= '0;
            acc       <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        m     <= sel_a;
                        q     <= sel_b;
                        id    <= gnt_idx;
                        acc   <= '0;
                        cnt   <= CW'(W);
                        ptr   <= IDW'((32'(gnt_idx) + 32'd1) % 32'(NREQ));
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= nxt_acc;
                    q   <= nxt_q;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_prod  <= {nxt_acc, nxt_q};
                        rsp_id    <= id;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
